// File: rtl/param_small_fifo.sv
// Parametrised synchronous FIFO with standard or first-word-fall-through read,
// programmable thresholds, occupancy count and sticky overflow/underflow flags.
module param_small_fifo #(
    parameter int WIDTH                = 72,
    parameter int MAX_DEPTH_BITS       = 3,
    parameter int FWFT                 = 0,
    parameter int PROG_FULL_THRESHOLD  = (2 ** MAX_DEPTH_BITS) - 1,
    parameter int PROG_EMPTY_THRESHOLD = 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [WIDTH-1:0]          din,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      nearly_full,
    output logic                      prog_full,
    output logic                      empty,
    output logic                      prog_empty,
    output logic [MAX_DEPTH_BITS:0]   count,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int MAX_DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam int CW        = MAX_DEPTH_BITS + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(MAX_DEPTH);
    localparam logic [CW-1:0] NFULL_C = CW'(MAX_DEPTH - 1);
    localparam logic [CW-1:0] PFULL_C = CW'(PROG_FULL_THRESHOLD);
    localparam logic [CW-1:0] PEMPT_C = CW'(PROG_EMPTY_THRESHOLD);

    logic [WIDTH-1:0]          mem [MAX_DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [CW-1:0]             count_q;
    logic                      wr_acc;
    logic                      rd_acc;

    // All status flags come straight from the registered count.
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign nearly_full = (count_q >= NFULL_C);
    assign prog_full   = (count_q >= PFULL_C);
    assign prog_empty  = (count_q <= PEMPT_C);

    // A full FIFO still takes a write when the same cycle pops a word.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + MAX_DEPTH_BITS'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + MAX_DEPTH_BITS'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A new error event wins over a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en & ~wr_acc) | (overflow  & ~clr_err);
            underflow <= (rd_en & empty)   | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign dout = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign dout = dout_q;
        end
    endgenerate

endmodule
